// File: rtl/systolic_feeder_if.sv
// Bus bundle between the tile source, the systolic feeder and the array.
// Valid/ready on the input beat: a beat transfers on a rising clock edge
// where in_valid and in_ready are both high; the source keeps in_act and
// in_weight stable while in_valid is high and in_ready is low. The array
// side (activations, weights, load) has no back-pressure.
interface systolic_feeder_if #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 4
);
    localparam int BUS_W = ARRAY_SIZE * DATA_WIDTH;

    // Input beat port
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_act;
    logic [BUS_W-1:0] in_weight;

    // Array-facing side
    logic [BUS_W-1:0] activations;
    logic [BUS_W-1:0] weights;
    logic             load;
    logic             busy;
    logic             done;

    // Feeder side
    modport slave (
        input  in_valid,
        input  in_act,
        input  in_weight,
        output in_ready,
        output activations,
        output weights,
        output load,
        output busy,
        output done
    );

    // Tile source / array / bench side
    modport master (
        output in_valid,
        output in_act,
        output in_weight,
        input  in_ready,
        input  activations,
        input  weights,
        input  load,
        input  busy,
        input  done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Systolic array feeder: buffers one activation tile and one weight tile
// (one beat per step k), then replays them as diagonally skewed wavefronts
// where lane i lags lane 0 by i cycles, drains with zeros so the last partial
// sums reach the output row, and pulses done before taking the next tile.
module systolic_feeder #(
    parameter int ARRAY_SIZE   = 4,
    parameter int DATA_WIDTH   = 4,
    parameter int DRAIN_CYCLES = ARRAY_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,     // asynchronous, active low
    systolic_feeder_if.slave     bus,
    output logic [1:0]           dbg_state  // current FSM state, for checkers
);

    localparam int BUS_W     = ARRAY_SIZE * DATA_WIDTH;
    localparam int BEAT_W    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int LAST_STEP = 2 * ARRAY_SIZE - 2;
    localparam int CNT_MAX   = (LAST_STEP > DRAIN_CYCLES) ? LAST_STEP : DRAIN_CYCLES;
    // One spare code so the width is never zero and always holds ARRAY_SIZE
    localparam int CNT_W     = $clog2(CNT_MAX + 2);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]     step_q, step_d;
    logic [BUS_W-1:0]     act_q, act_d;
    logic [BUS_W-1:0]     wgt_q, wgt_d;

    // Tile buffers indexed [beat k][lane]; activations hold A[lane][k],
    // weights hold W[k][lane]. Both read back at beat index (step - lane).
    logic [DATA_WIDTH-1:0] act_buf_q [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_WIDTH-1:0] act_buf_d [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_WIDTH-1:0] wgt_buf_q [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_WIDTH-1:0] wgt_buf_d [ARRAY_SIZE][ARRAY_SIZE];

    logic                 accept;
    logic [CNT_W-1:0]     sel_step;
    logic [CNT_W-1:0]     diff;
    logic [BUS_W-1:0]     skew_act;
    logic [BUS_W-1:0]     skew_wgt;

    assign accept = (state_q == S_FILL) && bus.in_valid;

    // Buffer write: the accepted beat lands at index beat_q in every lane
    always_comb begin
        act_buf_d = act_buf_q;
        wgt_buf_d = wgt_buf_q;
        if (accept) begin
            for (int l = 0; l < ARRAY_SIZE; l++) begin
                act_buf_d[beat_q][l] = bus.in_act[l*DATA_WIDTH +: DATA_WIDTH];
                wgt_buf_d[beat_q][l] = bus.in_weight[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Tile storage carries no reset; contents are only read after a full fill
    always_ff @(posedge clk) begin
        act_buf_q <= act_buf_d;
        wgt_buf_q <= wgt_buf_d;
    end

    // Skewed wavefront for the step about to be shown. Reading the *_d view
    // lets the final beat feed step 0 on the same edge it is accepted.
    always_comb begin
        sel_step = (state_q == S_FILL) ? '0 : (step_q + CNT_W'(1));
        diff     = '0;
        skew_act = '0;
        skew_wgt = '0;
        for (int l = 0; l < ARRAY_SIZE; l++) begin
            if (sel_step >= CNT_W'(l)) begin
                diff = sel_step - CNT_W'(l);
                if (diff < CNT_W'(ARRAY_SIZE)) begin
                    skew_act[l*DATA_WIDTH +: DATA_WIDTH] = act_buf_d[diff[BEAT_W-1:0]][l];
                    skew_wgt[l*DATA_WIDTH +: DATA_WIDTH] = wgt_buf_d[diff[BEAT_W-1:0]][l];
                end
            end
        end
    end

    // Next-state logic: fill beats, stream 2N-1 steps, drain, one done cycle
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        step_d  = step_q;
        act_d   = '0;
        wgt_d   = '0;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (beat_q == BEAT_W'(ARRAY_SIZE - 1)) begin
                        state_d = S_STREAM;
                        beat_d  = '0;
                        step_d  = '0;
                        act_d   = skew_act;
                        wgt_d   = skew_wgt;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_STREAM: begin
                if (step_q == CNT_W'(LAST_STEP)) begin
                    step_d  = '0;
                    state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else begin
                    step_d = step_q + CNT_W'(1);
                    act_d  = skew_act;
                    wgt_d  = skew_wgt;
                end
            end
            S_DRAIN: begin
                // Buses stay zero; step_q counts drain cycles from 0
                if (int'(step_q) >= DRAIN_CYCLES - 1) begin
                    step_d  = '0;
                    state_d = S_DONE;
                end else begin
                    step_d = step_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_FILL;
                beat_d  = '0;
            end
            default: begin
                state_d = S_FILL;
                beat_d  = '0;
                step_d  = '0;
            end
        endcase
    end

    // Control and output registers; reset aborts any tile at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FILL;
            beat_q  <= '0;
            step_q  <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            step_q  <= step_d;
            act_q   <= act_d;
            wgt_q   <= wgt_d;
        end
    end

    assign bus.activations = act_q;
    assign bus.weights     = wgt_q;
    assign bus.load        = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign bus.busy        = (state_q != S_FILL);
    assign bus.done        = (state_q == S_DONE);
    assign bus.in_ready    = (state_q == S_FILL);
    assign dbg_state       = state_q;

endmodule
